// File: rtl/cell_painter.sv
// cell_painter: expands one grid-cell update into a row-major
// stream of RGB565 pixel beats for the display writer.
module cell_painter #(
  parameter int CELL_PX = 20,
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [3:0]  cell_x,
  input  logic [3:0]  cell_y,
  input  logic [2:0]  cell_code,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [8:0]  px_x,
  output logic [7:0]  px_y,
  output logic [15:0] px_color,
  output logic        px_last,
  output logic        busy,
  output logic        err_drop
);

  localparam int LW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam logic [LW-1:0] LMAX = LW'(CELL_PX - 1);

  typedef enum logic {IDLE, PAINT} state_t;

  state_t        state, state_nx;
  logic [8:0]    base_x, bx_in;
  logic [7:0]    base_y, by_in;
  logic [2:0]    code;
  logic [LW-1:0] lx, ly, lx_nx, ly_nx;
  logic          take, in_range, fire, done;

  function automatic logic [15:0] color_of(
    input logic [2:0]    c,
    input logic [LW-1:0] x,
    input logic [LW-1:0] y
  );
    logic [15:0] col;
    logic        gap;
    unique case (c)
      3'd0:    col = 16'h0000;
      3'd1:    col = 16'h07E0;
      3'd2:    col = 16'h03E0;
      3'd3:    col = 16'hF800;
      3'd4:    col = 16'h8410;
      default: col = 16'hF81F;
    endcase
    // blank and border cells are solid; others leave a 1-px gap
    gap = ((x == LMAX) || (y == LMAX)) && (c != 3'd0) && (c != 3'd4);
    return gap ? 16'h0000 : col;
  endfunction

  assign bx_in    = 9'(cell_x) * 9'(CELL_PX);
  assign by_in    = 8'(cell_y) * 8'(CELL_PX);
  assign in_range = (32'(cell_x) < GRID_W) && (32'(cell_y) < GRID_H);
  assign take     = upd_valid && (state == IDLE);
  assign fire     = px_valid && px_ready;
  assign done     = fire && px_last;

  always_comb begin
    lx_nx = lx + 1'b1;
    ly_nx = ly;
    if (lx == LMAX) begin
      lx_nx = '0;
      ly_nx = ly + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take && in_range) state_nx = PAINT;
      PAINT:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    upd_ready = (state == IDLE);
    busy      = (state == PAINT);
    px_valid  = (state == PAINT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_x   <= '0;
      base_y   <= '0;
      code     <= '0;
      lx       <= '0;
      ly       <= '0;
      px_x     <= '0;
      px_y     <= '0;
      px_color <= '0;
      px_last  <= 1'b0;
      err_drop <= 1'b0;
    end else if (take) begin
      if (in_range) begin
        base_x   <= bx_in;
        base_y   <= by_in;
        code     <= cell_code;
        lx       <= '0;
        ly       <= '0;
        px_x     <= bx_in;
        px_y     <= by_in;
        px_color <= color_of(cell_code, '0, '0);
        px_last  <= (CELL_PX == 1);
      end else begin
        err_drop <= 1'b1;
      end
    end else if (fire) begin
      if (px_last) begin
        lx      <= '0;
        ly      <= '0;
        px_last <= 1'b0;
      end else begin
        lx       <= lx_nx;
        ly       <= ly_nx;
        px_x     <= base_x + 9'(lx_nx);
        px_y     <= base_y + 8'(ly_nx);
        px_color <= color_of(code, lx_nx, ly_nx);
        px_last  <= (lx_nx == LMAX) && (ly_nx == LMAX);
      end
    end
  end

endmodule
